cnt_seq_ctrl: RTL and testbench
===============================

CNT_SEQ_CTRL -- requirements
Module: cnt_seq_ctrl

Interface
REQ-001 SHALL have parameter W, default 4, counter width in bits.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port mr  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  begin run in IDLE, resume in PAUSE.
REQ-005 SHALL have port stop  input  1  pause in RUN, abort in PAUSE.
REQ-006 SHALL have port limit  input  W  terminal count per pass, sampled on accepted start from IDLE.
REQ-007 SHALL have port passes  input  W  number of passes per run, sampled with limit; 0 is treated as 1.
REQ-008 SHALL have port q  output  W  current count.
REQ-009 SHALL have port pass_cnt  output  W  completed passes in current run.
REQ-010 SHALL have port co  output  1  carry-out, combinational: high when state is RUN and q equals latched limit.
REQ-011 SHALL have port busy  output  1  high in RUN or PAUSE.
REQ-012 SHALL have port done  output  1  high for exactly one cycle in state DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-014 IDLE: on start=1 and stop=0 at an edge, SHALL latch limit/passes, clear q and pass_cnt, and go to RUN.
REQ-015 RUN: each edge SHALL increment q by 1 when q is below latched limit.
REQ-016 RUN: when q equals latched limit, the edge SHALL wrap q to 0 and increment pass_cnt, so one pass takes limit+1 cycles.
REQ-017 RUN: when q equals limit and pass_cnt equals latched passes minus 1, the edge SHALL wrap q to 0, leave pass_cnt at latched passes, and go to DONE.
REQ-018 RUN: stop=1 SHALL go to PAUSE with q and pass_cnt frozen; stop takes priority over the count update on that edge.
REQ-019 PAUSE: start=1 with stop=0 SHALL return to RUN; counting resumes on the following edge.
REQ-020 PAUSE: stop=1 SHALL abort to IDLE and clear q and pass_cnt.
REQ-021 PAUSE: start and stop together SHALL be treated as stop.
REQ-022 DONE: SHALL return to IDLE unconditionally after one cycle, ignoring start and stop.
REQ-023 start in RUN SHALL be ignored.
REQ-024 limit/passes changes after latching SHALL have no effect until the next run.
REQ-025 limit=0 SHALL give one-cycle passes, with co high every RUN cycle.
REQ-026 limit=all-ones SHALL wrap from 2^W-1 to 0 with no overflow flag.
REQ-027 pass_cnt SHALL hold its final value in DONE and IDLE until the next accepted start.

Reset
REQ-028 mr=0 SHALL immediately force state IDLE, q=0, pass_cnt=0, latched limit/passes=0, busy=0, done=0, co=0, regardless of clk.
REQ-029 Reset asserted mid-run SHALL abandon the run; no done pulse SHALL follow release.
REQ-030 After mr release, the first edge SHALL behave as IDLE.

Structure
REQ-031 State encodings (IDLE/RUN/PAUSE/DONE) and default width W=4 SHALL live in a shared package.
REQ-032 Counting SHALL be delegated to one sub-module, cnt_core (W-bit counter with en, sync clear, co at programmable terminal), instantiated once; cnt_seq_ctrl holds the FSM, latches and pass counter.

Verification
REQ-033 Reset: mr=0 mid-RUN with q=5 -> q=0, pass_cnt=0, busy=0 immediately, before any clk edge.
REQ-034 Basic run: limit=3, passes=2, start for 1 cycle -> q sequence 0,1,2,3,0,1,2,3,0; co high on both q=3 cycles; done high once 8 cycles after start edge; pass_cnt ends at 2.
REQ-035 Pause/resume: limit=9, passes=1, stop at q=4 for 3 cycles then start -> q holds 4 while paused, then continues to 5..9; done follows q=9.
REQ-036 Abort: in PAUSE assert stop -> IDLE next edge, q=0, no done pulse.
REQ-037 Boundaries: limit=0, passes=0 -> single RUN cycle with co=1, then DONE; limit=15, passes=1 -> 16 RUN cycles, q wraps 15->0.
REQ-038 Simultaneous: start+stop in IDLE -> stays IDLE; start+stop in RUN -> PAUSE.

Source files
------------

// File: rtl/cnt_seq_ctrl_pkg.sv
// Shared types for the pass-sequencing counter controller.
// Holds the FSM state encoding and the default counter width.
package cnt_seq_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cnt_seq_ctrl_core.sv
// cnt_core: W-bit counter, wraps to 0 at a programmable terminal.
// Ports: clk, rst_n (async low), en, clr (sync), term -> q, co.
module cnt_core #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic [W-1:0] q,
  output logic         co
);

  // Raw terminal compare; the controller qualifies it by state.
  assign co = (q == term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= co ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Run/pause/abort sequencer for a multi-pass counter.
// Ports: clk, mr, start, stop, limit, passes -> q, pass_cnt, co, busy, done.
module cnt_seq_ctrl
  import cnt_seq_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         mr,
  input  logic         start,
  input  logic         stop,
  input  logic [W-1:0] limit,
  input  logic [W-1:0] passes,
  output logic [W-1:0] q,
  output logic [W-1:0] pass_cnt,
  output logic         co,
  output logic         busy,
  output logic         done
);

  state_t       st, st_nx;
  logic [W-1:0] lim, lim_nx;
  logic [W-1:0] pas, pas_nx;
  logic [W-1:0] pc_nx;
  logic         en, clr;
  logic         core_co;

  cnt_core #(.W(W)) u_core (
    .clk   (clk),
    .rst_n (mr),
    .en    (en),
    .clr   (clr),
    .term  (lim),
    .q     (q),
    .co    (core_co)
  );

  always_ff @(posedge clk or negedge mr) begin
    if (!mr) begin
      st       <= S_IDLE;
      lim      <= '0;
      pas      <= '0;
      pass_cnt <= '0;
    end else begin
      st       <= st_nx;
      lim      <= lim_nx;
      pas      <= pas_nx;
      pass_cnt <= pc_nx;
    end
  end

  always_comb begin
    st_nx  = st;
    lim_nx = lim;
    pas_nx = pas;
    pc_nx  = pass_cnt;
    en     = 1'b0;
    clr    = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (start && !stop) begin
          lim_nx = limit;
          // A request for zero passes still runs once.
          pas_nx = (passes == '0) ? W'(1) : passes;
          pc_nx  = '0;
          clr    = 1'b1;
          st_nx  = S_RUN;
        end
      end
      S_RUN: begin
        // stop wins over the count update on the same edge.
        if (stop) begin
          st_nx = S_PAUSE;
        end else begin
          en = 1'b1;
          if (core_co) begin
            if (pass_cnt == pas - W'(1)) begin
              pc_nx = pas;
              st_nx = S_DONE;
            end else begin
              pc_nx = pass_cnt + W'(1);
            end
          end
        end
      end
      S_PAUSE: begin
        if (stop) begin
          st_nx = S_IDLE;
          pc_nx = '0;
          clr   = 1'b1;
        end else if (start) begin
          st_nx = S_RUN;
        end
      end
      S_DONE: begin
        st_nx = S_IDLE;
      end
      default: begin
        st_nx = S_IDLE;
      end
    endcase
  end

  assign co   = (st == S_RUN) && core_co;
  assign busy = (st == S_RUN) || (st == S_PAUSE);
  assign done = (st == S_DONE);

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Self-checking bench for cnt_seq_ctrl.
// Directed scenarios plus random traffic against a tick-count model.
module tb_cnt_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         mr = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] passes = '0;
  logic [W-1:0] q;
  logic [W-1:0] pass_cnt;
  logic         co;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail = 0;

  // Model: run progress is one integer of elapsed RUN ticks;
  // q and pass_cnt are derived from it by division.
  int m_mode;
  int m_lim;
  int m_pas;
  int m_ticks;

  cnt_seq_ctrl #(.W(W)) dut (
    .clk      (clk),
    .mr       (mr),
    .start    (start),
    .stop     (stop),
    .limit    (limit),
    .passes   (passes),
    .q        (q),
    .pass_cnt (pass_cnt),
    .co       (co),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode  = 0;
    m_lim   = 0;
    m_pas   = 0;
    m_ticks = 0;
  endtask

  task automatic m_edge();
    if (!mr) begin
      m_reset();
      return;
    end
    case (m_mode)
      0: if (start && !stop) begin
        m_lim   = int'(limit);
        m_pas   = (passes == 0) ? 1 : int'(passes);
        m_ticks = 0;
        m_mode  = 1;
      end
      1: if (stop) m_mode = 2;
      else begin
        m_ticks++;
        if (m_ticks == (m_lim + 1) * m_pas) m_mode = 3;
      end
      2: if (stop) begin
        m_mode  = 0;
        m_ticks = 0;
      end else if (start) m_mode = 1;
      default: m_mode = 0;
    endcase
  endtask

  task automatic check_all(string tag);
    int eq, ep;
    eq = m_ticks % (m_lim + 1);
    ep = m_ticks / (m_lim + 1);
    chk({tag, ".q"}, int'(q), eq);
    chk({tag, ".pass_cnt"}, int'(pass_cnt), ep);
    chk({tag, ".co"}, int'(co), int'(m_mode == 1 && eq == m_lim));
    chk({tag, ".busy"}, int'(busy), int'(m_mode == 1 || m_mode == 2));
    chk({tag, ".done"}, int'(done), int'(m_mode == 3));
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    m_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic go(int lim, int pas);
    limit  = W'(lim);
    passes = W'(pas);
    start  = 1'b1;
    stop   = 1'b0;
    cyc("start");
    start  = 1'b0;
    limit  = W'($urandom);
    passes = W'($urandom);
  endtask

  initial begin
    int rc;
    m_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    mr = 1'b1;
    cyc("idle");

    // Async reset mid-run at q=5.
    go(9, 1);
    repeat (5) cyc("pre_rst");
    chk("pre_rst_q5", int'(q), 5);
    #2;
    mr = 1'b0;
    #1;
    chk("arst_q", int'(q), 0);
    chk("arst_pc", int'(pass_cnt), 0);
    chk("arst_busy", int'(busy), 0);
    m_reset();
    @(negedge clk);
    mr = 1'b1;
    repeat (3) begin
      cyc("post_rst");
      chk("post_rst_done", int'(done), 0);
    end

    // Basic run: limit 3, passes 2.
    go(3, 2);
    for (int i = 0; i < 9; i++) begin
      chk("basic_q", int'(q), (i < 8) ? i % 4 : 0);
      chk("basic_done", int'(done), int'(i == 8));
      chk("basic_co", int'(co), int'(i == 3 || i == 7));
      if (i == 8) chk("basic_pc", int'(pass_cnt), 2);
      cyc("basic");
    end
    chk("basic_hold_pc", int'(pass_cnt), 2);

    // Pause at q=4, idle 2 cycles, resume.
    go(9, 1);
    repeat (4) cyc("p_run");
    stop = 1'b1;
    cyc("p_stop");
    stop = 1'b0;
    repeat (2) begin
      cyc("p_hold");
      chk("p_hold_q", int'(q), 4);
    end
    start = 1'b1;
    cyc("p_resume");
    start = 1'b0;
    rc = 0;
    while (!done && rc < 20) begin
      cyc("p_tail");
      rc++;
    end
    chk("p_tail_len", rc, 6);
    cyc("p_idle");

    // Abort from PAUSE.
    go(7, 3);
    repeat (3) cyc("a_run");
    stop = 1'b1;
    cyc("a_pause");
    cyc("a_abort");
    stop = 1'b0;
    chk("a_abort_q", int'(q), 0);
    chk("a_abort_busy", int'(busy), 0);
    repeat (3) begin
      cyc("a_after");
      chk("a_no_done", int'(done), 0);
    end

    // Boundaries.
    go(0, 0);
    chk("b0_co", int'(co), 1);
    cyc("b0_done");
    chk("b0_done_hi", int'(done), 1);
    cyc("b0_idle");
    go(15, 1);
    rc = 0;
    while (!done && rc < 40) begin
      cyc("b15");
      rc++;
    end
    chk("b15_len", rc, 16);
    chk("b15_wrap_q", int'(q), 0);
    cyc("b15_idle");

    // Simultaneous start+stop.
    limit = 4'd5;
    passes = 4'd1;
    start = 1'b1;
    stop = 1'b1;
    cyc("ss_idle");
    chk("ss_idle_busy", int'(busy), 0);
    stop = 1'b0;
    cyc("ss_go");
    cyc("ss_run");
    stop = 1'b1;
    cyc("ss_run_pause");
    chk("ss_pause_busy", int'(busy), 1);
    start = 1'b0;
    cyc("ss_abort");

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      stop   = ($urandom_range(0, 11) == 0);
      limit  = W'($urandom_range(0, 15) < 12 ?
                  $urandom_range(0, 5) : $urandom);
      passes = W'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) begin
        #2;
        mr = 1'b0;
        #1;
        m_reset();
        check_all("rnd_arst");
        @(negedge clk);
        mr = 1'b1;
      end
      cyc("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
